idle_timeout_multi: RTL and testbench

- Multi-channel successor to the keyboard idle detector.
- Each channel watches its own activity strobe, such as a key make, joystick move or game event.
- After a programmable idle time in milliseconds, a channel raises a programmable-length pulse and a sticky idle level.
- Optional periodic re-fire while the channel stays idle, for attract-mode or demo triggers in the Pac-Man top level.
- One shared prescaler derives a millisecond tick, so per-channel counters stay narrow.

---
 rtl/idle_timeout_pkg.sv | 19 +
 rtl/idle_tick_prescaler.sv | 45 ++++
 rtl/idle_timeout_multi.sv | 152 +++++++++++++++
 tb/tb_idle_timeout_multi.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idle_timeout_pkg.sv
// Shared types and helpers for the multi-channel idle timeout block.
//   idle_state_t : per-channel state (COUNT, PULSE, HOLD)
//   calc_div     : clk cycles per timeout tick
package idle_timeout_pkg;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } idle_state_t;

  // Prescaler division ratio; 0 flags an unusable tick rate.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    if (tick_hz == 0) return 0;
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/idle_tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every DIV clk cycles.
//   clk    : system clock
//   resetN : async active-low reset
//   tick   : high for one cycle while the count sits at DIV-1
module idle_tick_prescaler
  import idle_timeout_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 31_500_000,
  parameter int unsigned TICK_HZ     = 1000
) (
  input  logic clk,
  input  logic resetN,
  output logic tick
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  if (DIV < 1) begin : g_div_check
    $error("idle_tick_prescaler: CLK_FREQ_HZ/TICK_HZ must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count; tick is registered so it is high exactly while cnt_q == LAST.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/idle_timeout_multi.sv
// Multi-channel idle detector: each channel fires a pulse and a sticky idle
// level after timeout_ms ticks without activity, optionally re-firing every
// repeat_ms ticks while it stays idle.
//   clk, resetN   : clock, async active-low reset
//   activity      : per-channel activity (high = not idle)
//   enable        : per-channel enable (low behaves like held activity)
//   repeat_en     : per-channel periodic re-fire mode
//   timeout_ms    : first-fire idle time in ticks (0 = never fire)
//   repeat_ms     : re-fire interval in ticks (0 = one-shot)
//   pulse_cycles  : fire pulse length in clk cycles (0 acts as 1)
//   idle_pulse    : per-channel fire pulse
//   idle_level    : per-channel sticky idle level
//   any_pulse     : OR of idle_pulse, same timing
//   tick          : shared prescaler tick
module idle_timeout_multi
  import idle_timeout_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CLK_FREQ_HZ = 31_500_000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned TIME_W      = 16,
  parameter int unsigned PULSE_W     = 24
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [NUM_CH-1:0]  activity,
  input  logic [NUM_CH-1:0]  enable,
  input  logic [NUM_CH-1:0]  repeat_en,
  input  logic [TIME_W-1:0]  timeout_ms,
  input  logic [TIME_W-1:0]  repeat_ms,
  input  logic [PULSE_W-1:0] pulse_cycles,
  output logic [NUM_CH-1:0]  idle_pulse,
  output logic [NUM_CH-1:0]  idle_level,
  output logic               any_pulse,
  output logic               tick
);

  logic              tick_w;
  logic [NUM_CH-1:0] pulse_d_vec;
  logic              any_pulse_q;

  idle_tick_prescaler #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TICK_HZ     (TICK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .resetN (resetN),
    .tick   (tick_w)
  );

  assign tick = tick_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    idle_state_t        state_q, state_d;
    logic [TIME_W-1:0]  tcnt_q, tcnt_d;
    logic [PULSE_W-1:0] pcnt_q, pcnt_d;
    logic               fired_q, fired_d;
    logic               pulse_q, pulse_d;
    logic               level_q, level_d;
    logic               clr;
    logic [TIME_W-1:0]  target;
    logic [TIME_W:0]    tcnt_inc;

    assign clr = activity[i] | ~enable[i];

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        state_q <= COUNT;
        tcnt_q  <= '0;
        pcnt_q  <= '0;
        fired_q <= 1'b0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        tcnt_q  <= tcnt_d;
        pcnt_q  <= pcnt_d;
        fired_q <= fired_d;
        pulse_q <= pulse_d;
        level_q <= level_d;
      end
    end

    // Next state. The pulse counter counts down from the latched length-1;
    // the tick counter is widened by one bit so +1 cannot wrap.
    always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      pcnt_d   = pcnt_q;
      fired_d  = fired_q;
      target   = fired_q ? repeat_ms : timeout_ms;
      tcnt_inc = {1'b0, tcnt_q} + (TIME_W+1)'(1);

      if (clr) begin
        state_d = COUNT;
        tcnt_d  = '0;
        pcnt_d  = '0;
        fired_d = 1'b0;
      end else begin
        unique case (state_q)
          COUNT: begin
            if ((target != '0) && tick_w) begin
              if (tcnt_inc >= {1'b0, target}) begin
                state_d = PULSE;
                tcnt_d  = '0;
                fired_d = 1'b1;
                pcnt_d  = (pulse_cycles == '0) ? '0 : pulse_cycles - PULSE_W'(1);
              end else begin
                tcnt_d = tcnt_inc[TIME_W-1:0];
              end
            end
          end
          PULSE: begin
            if (pcnt_q == '0) begin
              state_d = (repeat_en[i] && (repeat_ms != '0)) ? COUNT : HOLD;
            end else begin
              pcnt_d = pcnt_q - PULSE_W'(1);
            end
          end
          HOLD: begin
            state_d = HOLD;
          end
          default: begin
            state_d = COUNT;
          end
        endcase
      end
    end

    // Outputs registered from the next state so they track it with no lag.
    always_comb begin
      pulse_d = (state_d == PULSE);
      level_d = fired_d;
    end

    assign pulse_d_vec[i] = pulse_d;
    assign idle_pulse[i]  = pulse_q;
    assign idle_level[i]  = level_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      any_pulse_q <= 1'b0;
    end else begin
      any_pulse_q <= |pulse_d_vec;
    end
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_idle_timeout_multi.sv
module tb_idle_timeout_multi;

  localparam int NCH = 2;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  activity, enable, repeat_en;
  logic [15:0] timeout_ms, repeat_ms;
  logic [23:0] pulse_cycles;
  logic [1:0]  idle_pulse, idle_level;
  logic        any_pulse, tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idle_timeout_multi #(
    .NUM_CH      (NCH),
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100),
    .TIME_W      (16),
    .PULSE_W     (24)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .activity     (activity),
    .enable       (enable),
    .repeat_en    (repeat_en),
    .timeout_ms   (timeout_ms),
    .repeat_ms    (repeat_ms),
    .pulse_cycles (pulse_cycles),
    .idle_pulse   (idle_pulse),
    .idle_level   (idle_level),
    .any_pulse    (any_pulse),
    .tick         (tick)
  );

  // Reference model: edges since reset, ticks seen while idle, remaining
  // pulse cycles, whether the channel has fired, whether it is parked.
  int m_edges;
  int m_ticks [NCH];
  int m_left  [NCH];
  bit m_fired [NCH];
  bit m_held  [NCH];

  task automatic model_reset();
    m_edges = 0;
    for (int c = 0; c < NCH; c++) begin
      m_ticks[c] = 0; m_left[c] = 0; m_fired[c] = 0; m_held[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit tick_pre;
    int target;
    tick_pre = ((m_edges % DIV) == DIV - 1);
    m_edges++;
    for (int c = 0; c < NCH; c++) begin
      if (activity[c] || !enable[c]) begin
        m_ticks[c] = 0; m_left[c] = 0; m_fired[c] = 0; m_held[c] = 0;
      end else if (m_left[c] > 0) begin
        m_left[c]--;
        if (m_left[c] == 0 && !(repeat_en[c] && repeat_ms != 0)) m_held[c] = 1;
      end else if (!m_held[c]) begin
        target = m_fired[c] ? int'(repeat_ms) : int'(timeout_ms);
        if (target != 0 && tick_pre) begin
          if (m_ticks[c] + 1 >= target) begin
            m_left[c]  = (pulse_cycles == 0) ? 1 : int'(pulse_cycles);
            m_fired[c] = 1;
            m_ticks[c] = 0;
          end else begin
            m_ticks[c]++;
          end
        end
      end
    end
  endtask

  // {tick, any_pulse, idle_level[1:0], idle_pulse[1:0]}
  function automatic logic [5:0] exp_vec();
    logic [1:0] p, l;
    for (int c = 0; c < NCH; c++) begin
      p[c] = (m_left[c] > 0);
      l[c] = m_fired[c];
    end
    return {((m_edges % DIV) == DIV - 1), |p, l, p};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Holds the listed channels active until a tick has been consumed, then
  // releases them so the next tick is a full period away.
  task automatic sync_release(input logic [1:0] rel);
    int n;
    activity = activity | rel;
    n = 0;
    while (!tick && n < 20) begin step(); n++; end
    step();
    activity = activity & ~rel;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    activity = 2'b11; enable = 2'b11; repeat_en = 2'b00;
    timeout_ms = 16'd3; repeat_ms = 16'd0; pulse_cycles = 24'd4;
    model_reset();
    #12;
    checks++;
    if ({tick, any_pulse, idle_level, idle_pulse} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", {tick, any_pulse, idle_level, idle_pulse}, 6'b0);
    end
    @(negedge clk); resetN = 1'b1;
    repeat (5) begin
      step();
      checks++;
      if ({tick, any_pulse, idle_level, idle_pulse} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_run t=%0t got %b exp %b", $time, {tick, any_pulse, idle_level, idle_pulse}, exp_vec());
      end
    end
  endtask

  task automatic test_one_shot();
    int first, width, rises;
    logic prev;
    enable = 2'b01; repeat_en = 2'b00; timeout_ms = 16'd3; repeat_ms = 16'd0; pulse_cycles = 24'd4;
    activity = 2'b11;
    sync_release(2'b01);
    first = -1; width = 0; rises = 0; prev = 1'b0;
    for (int s = 1; s <= 240; s++) begin
      step();
      checks++;
      if ({tick, any_pulse, idle_level, idle_pulse} !== exp_vec()) begin
        errors++;
        $display("FAIL one_shot step=%0d got %b exp %b", s, {tick, any_pulse, idle_level, idle_pulse}, exp_vec());
      end
      if (idle_pulse[0]) width++;
      if (idle_pulse[0] && !prev) begin rises++; if (first < 0) first = s; end
      prev = idle_pulse[0];
    end
    checks++;
    if (first != 30 || width != 4 || rises != 1 || idle_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL one_shot_shape first=%0d width=%0d rises=%0d level=%b exp 30/4/1/1", first, width, rises, idle_level[0]);
    end
  endtask

  task automatic test_repeat();
    int first, last, rises;
    logic prev;
    enable = 2'b11; repeat_en = 2'b10; timeout_ms = 16'd2; repeat_ms = 16'd3; pulse_cycles = 24'd2;
    activity = 2'b01;
    sync_release(2'b10);
    first = -1; last = -1; rises = 0; prev = 1'b0;
    for (int s = 1; s <= 150; s++) begin
      step();
      checks++;
      if ({tick, any_pulse, idle_level, idle_pulse} !== exp_vec()) begin
        errors++;
        $display("FAIL repeat step=%0d got %b exp %b", s, {tick, any_pulse, idle_level, idle_pulse}, exp_vec());
      end
      if (idle_pulse[1] && !prev) begin rises++; last = s; if (first < 0) first = s; end
      prev = idle_pulse[1];
    end
    checks++;
    if (first != 20 || last != 140 || rises != 5) begin
      errors++;
      $display("FAIL repeat_timing first=%0d last=%0d rises=%0d exp 20/140/5", first, last, rises);
    end
  endtask

  task automatic test_activity_mid_pulse();
    int n;
    enable = 2'b01; repeat_en = 2'b00; timeout_ms = 16'd3; repeat_ms = 16'd0; pulse_cycles = 24'd4;
    activity = 2'b11;
    sync_release(2'b01);
    n = 0;
    while (!idle_pulse[0] && n < 50) begin step(); n++; end
    checks++;
    if (!idle_pulse[0]) begin
      errors++;
      $display("FAIL mid_pulse_wait got no pulse after %0d cycles exp pulse", n);
    end
    step();
    activity[0] = 1'b1;
    step();
    checks++;
    if (idle_pulse[0] !== 1'b0 || idle_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_pulse_clear got pulse=%b level=%b exp 0/0", idle_pulse[0], idle_level[0]);
    end
    activity[0] = 1'b0;
    n = 0;
    while (!idle_pulse[0] && n < 40) begin
      step(); n++;
      checks++;
      if ({tick, any_pulse, idle_level, idle_pulse} !== exp_vec()) begin
        errors++;
        $display("FAIL mid_pulse_refire step=%0d got %b exp %b", n, {tick, any_pulse, idle_level, idle_pulse}, exp_vec());
      end
    end
    checks++;
    if (n < 21 || n > 30) begin
      errors++;
      $display("FAIL mid_pulse_delay got %0d cycles exp 21..30", n);
    end
  endtask

  task automatic test_disable_zero();
    int pulses, n;
    enable = 2'b11; repeat_en = 2'b00; timeout_ms = 16'd0; repeat_ms = 16'd0; pulse_cycles = 24'd4;
    activity = 2'b11; step(); activity = 2'b00;
    pulses = 0;
    for (int s = 0; s < 1000; s++) begin
      if (s == 500) begin timeout_ms = 16'd3; enable = 2'b00; end
      step();
      if (any_pulse || idle_pulse != 2'b00 || idle_level != 2'b00) pulses++;
      checks++;
      if ({tick, any_pulse, idle_level, idle_pulse} !== exp_vec()) begin
        errors++;
        $display("FAIL disable_zero step=%0d got %b exp %b", s, {tick, any_pulse, idle_level, idle_pulse}, exp_vec());
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL disable_zero_quiet got %0d active cycles exp 0", pulses);
    end
    enable = 2'b11; timeout_ms = 16'd1; pulse_cycles = 24'd0;
    n = 0;
    while (idle_pulse == 2'b00 && n < 30) begin step(); n++; end
    checks++;
    if (idle_pulse !== 2'b11) begin
      errors++;
      $display("FAIL zero_len_sync got %b exp 11", idle_pulse);
    end
    step();
    checks++;
    if (idle_pulse !== 2'b00 || idle_level !== 2'b11) begin
      errors++;
      $display("FAIL zero_len_width got pulse=%b level=%b exp 00/11", idle_pulse, idle_level);
    end
  endtask

  task automatic test_live_target();
    int n;
    enable = 2'b01; repeat_en = 2'b00; timeout_ms = 16'd10; pulse_cycles = 24'd3;
    activity = 2'b11; step(); activity = 2'b00;
    n = 0;
    while (m_ticks[0] != 5 && n < 100) begin step(); n++; end
    timeout_ms = 16'd4;
    n = 0;
    while (!tick && n < 12) begin
      step(); n++;
      checks++;
      if (idle_pulse[0] !== 1'b0) begin
        errors++;
        $display("FAIL live_target_early got pulse=%b exp 0", idle_pulse[0]);
      end
    end
    step();
    checks++;
    if (idle_pulse[0] !== 1'b1) begin
      errors++;
      $display("FAIL live_target_fire got pulse=%b exp 1", idle_pulse[0]);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    enable = 2'b01; repeat_en = 2'b00; timeout_ms = 16'd3; pulse_cycles = 24'd8;
    activity = 2'b11; step(); activity = 2'b00;
    n = 0;
    while (!idle_pulse[0] && n < 50) begin step(); n++; end
    step();
    #2 resetN = 1'b0;
    #1;
    checks++;
    if ({tick, any_pulse, idle_level, idle_pulse} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", {tick, any_pulse, idle_level, idle_pulse}, 6'b0);
    end
    model_reset();
    @(negedge clk); @(negedge clk); resetN = 1'b1;
    n = 0;
    while (!idle_pulse[0] && n < 40) begin
      step(); n++;
      checks++;
      if ({tick, any_pulse, idle_level, idle_pulse} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_refire step=%0d got %b exp %b", n, {tick, any_pulse, idle_level, idle_pulse}, exp_vec());
      end
    end
    checks++;
    if (n != 30) begin
      errors++;
      $display("FAIL reset_refire_delay got %0d cycles exp 30", n);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 3000; s++) begin
      if (s % 400 == 0) begin
        timeout_ms   = 16'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 4));
        repeat_ms    = 16'($urandom_range(0, 3));
        pulse_cycles = 24'($urandom_range(0, 5));
        repeat_en    = 2'($urandom_range(0, 3));
      end
      for (int c = 0; c < NCH; c++) begin
        activity[c] = ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 499) == 0) enable[c] = ~enable[c];
      end
      step();
      checks++;
      if ({tick, any_pulse, idle_level, idle_pulse} !== exp_vec()) begin
        errors++;
        $display("FAIL random step=%0d got %b exp %b", s, {tick, any_pulse, idle_level, idle_pulse}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_repeat();
    test_activity_mid_pulse();
    test_disable_zero();
    test_live_target();
    test_reset_mid_pulse();
    enable = 2'b11;
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
